// File: rtl/iob_fifo_sync_dp_ctrl.sv
// ---------------------------------------------------------------------------
// iob_fifo_sync_dp_ctrl
// Synchronous FIFO controller for an external dual-port byte-enable BRAM.
// Port A carries pushes (write pointer) and port B carries pops (read pointer).
// The BRAM read data arrives one cycle after en_b.
//
// Optional feature macro: IOB_FIFO_SYNC_FWFT_EN
//   undefined : standard mode. r_valid_o pulses for one cycle per accepted pop.
//   defined   : first-word-fall-through mode. A one-entry output register is
//               prefetched from the RAM, and r_valid_o means that the head word
//               is present on r_data_o.
// ---------------------------------------------------------------------------
module iob_fifo_sync_dp_ctrl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 4,
  parameter int ALMOST_FULL_TH = 2**ADDR_W-2
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                w_en_i,
  input  logic [DATA_W-1:0]   w_data_i,
  output logic                w_full_o,
  output logic                almost_full_o,
  input  logic                r_en_i,
  output logic [DATA_W-1:0]   r_data_o,
  output logic                r_valid_o,
  output logic                r_empty_o,
  output logic [ADDR_W:0]     level_o,
  output logic [DATA_W/8-1:0] ext_mem_we_a_o,
  output logic                ext_mem_en_a_o,
  output logic [ADDR_W-1:0]   ext_mem_addr_a_o,
  output logic [DATA_W-1:0]   ext_mem_d_a_o,
  output logic                ext_mem_en_b_o,
  output logic [ADDR_W-1:0]   ext_mem_addr_b_o,
  input  logic [DATA_W-1:0]   ext_mem_d_b_i
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_TH_L = (ADDR_W+1)'(ALMOST_FULL_TH);

  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_level;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  logic              w_active;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Both flags are decoded from registered state, so they change in the cycle
  // after the clock edge that moved the level.
  assign w_active = cke_i & ~rst_i;
  assign w_full   = (r_level == DEPTH_L);

  // A push while full is dropped, even when a pop is accepted in the same cycle.
  assign w_push   = w_active & w_en_i & ~w_full;

  // Port A writes the pushed word at the write pointer in the same cycle.
  assign ext_mem_en_a_o   = w_push;
  assign ext_mem_we_a_o   = {(DATA_W/8){w_push}};
  assign ext_mem_addr_a_o = r_wptr;
  assign ext_mem_d_a_o    = w_data_i;

  assign w_full_o      = w_full;
  assign almost_full_o = (r_level >= AF_TH_L);
  assign level_o       = r_level;
  assign r_valid_o     = r_valid;
  assign r_empty_o     = w_empty;

`ifdef IOB_FIFO_SYNC_FWFT_EN

  // Words held in the RAM only. r_level also counts the word that is in
  // flight from the RAM and the word in the output register.
  logic [ADDR_W:0] r_ram_level;
  logic            r_pend;
  logic            w_fetch;

  assign w_empty = ~r_valid;
  assign w_pop   = w_active & r_en_i & r_valid;

  // Start a prefetch only when the output register is empty and no read is
  // already in flight. The register is then free when the RAM data returns.
  assign w_fetch = w_active & (r_ram_level != '0) & ~r_valid & ~r_pend;

  assign ext_mem_en_b_o   = w_fetch;
  assign ext_mem_addr_b_o = r_rptr;
  assign r_data_o         = r_data;

  // Update the pointers, the occupancy counts and the prefetched output register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs and the order of the statements does
  // not matter.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_ram_level <= '0;
      r_pend      <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_level     <= '0;
        r_ram_level <= '0;
        r_pend      <= 1'b0;
        r_valid     <= 1'b0;
        r_data      <= '0;
      end else begin
        if (w_push)  r_wptr <= r_wptr + 1'b1;
        if (w_fetch) r_rptr <= r_rptr + 1'b1;

        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase

        case ({w_push, w_fetch})
          2'b10:   r_ram_level <= r_ram_level + 1'b1;
          2'b01:   r_ram_level <= r_ram_level - 1'b1;
          default: r_ram_level <= r_ram_level;
        endcase

        r_pend <= w_fetch;

        // A returning read and a consume never coincide: a fetch is only
        // issued while the output register is empty.
        if (r_pend) begin
          r_valid <= 1'b1;
          r_data  <= ext_mem_d_b_i;
        end else if (w_pop) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

`else

  assign w_empty = (r_level == '0);
  assign w_pop   = w_active & r_en_i & ~w_empty;

  assign ext_mem_en_b_o   = w_pop;
  assign ext_mem_addr_b_o = r_rptr;

  // The RAM output is valid during the r_valid pulse. After the pulse, the
  // captured copy holds the last popped word.
  assign r_data_o = r_valid ? ext_mem_d_b_i : r_data;

  // Update the pointers and the level, and register the pop strobe and the
  // last popped word.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its pre-edge inputs and the order of the statements does
  // not matter.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;

        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase

        r_valid <= w_pop;
        if (r_valid) r_data <= ext_mem_d_b_i;
      end
    end
  end

`endif

endmodule

// File: tb/tb_iob_fifo_sync_dp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_iob_fifo_sync_dp_ctrl
// Directed bench for the default (standard-mode) build of
// iob_fifo_sync_dp_ctrl with DATA_W=32 and ADDR_W=4. A behavioural
// dual-port BRAM sits next to the controller, as it would in the parent.
// ---------------------------------------------------------------------------
module tb_iob_fifo_sync_dp_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              cke;
  logic              rst;
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              almost_full;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_empty;
  logic [ADDR_W:0]   level;
  logic [3:0]        we_a;
  logic              en_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] d_a;
  logic              en_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] d_b;

  int n_cmp = 0;
  int n_bad = 0;

  iob_fifo_sync_dp_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALMOST_FULL_TH(14)
  ) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .rst_i(rst),
    .w_en_i(w_en), .w_data_i(w_data), .w_full_o(w_full),
    .almost_full_o(almost_full), .r_en_i(r_en), .r_data_o(r_data),
    .r_valid_o(r_valid), .r_empty_o(r_empty), .level_o(level),
    .ext_mem_we_a_o(we_a), .ext_mem_en_a_o(en_a), .ext_mem_addr_a_o(addr_a),
    .ext_mem_d_a_o(d_a), .ext_mem_en_b_o(en_b), .ext_mem_addr_b_o(addr_b),
    .ext_mem_d_b_i(d_b)
  );

  always #5 clk = ~clk;

  // Behavioural BRAM: port A has byte-enable writes. Port B has a registered
  // read, and the read output holds while en_b is low.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (en_a)
      for (int b = 0; b < 4; b++)
        if (we_a[b]) mem[addr_a][b*8 +: 8] <= d_a[b*8 +: 8];
    if (en_b) d_b <= mem[addr_b];
  end

  // Compare one observed value against its expected value, and count it.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock. The bench drives and samples 1 time unit after the
  // rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic we, input logic [DATA_W-1:0] wd, input logic re);
    w_en = we; w_data = wd; r_en = re;
  endtask

  initial begin
    arst_n = 1'b0; cke = 1'b1; rst = 1'b0;
    w_en = 1'b0; w_data = '0; r_en = 1'b0;
    #12;
    check("rst_level",   level,   0);
    check("rst_empty",   r_empty, 1);
    check("rst_full",    w_full,  0);
    check("rst_afull",   almost_full, 0);
    check("rst_valid",   r_valid, 0);
    check("rst_rdata",   r_data,  0);
    arst_n = 1'b1;
    tick();

    // Three pushes, then an asynchronous reset in the middle of the stream.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'hC0 + i, 0);
      tick();
    end
    set_in(0, 0, 0);
    check("pre_arst_level", level, 3);
    #2 arst_n = 1'b0;
    #1;
    check("arst_level", level, 0);
    check("arst_empty", r_empty, 1);
    check("arst_valid", r_valid, 0);
    #1 arst_n = 1'b1;
    tick();
    set_in(0, 0, 1);
    #1;
    check("arst_pop_en_b", en_b, 0);
    tick();
    check("arst_pop_valid", r_valid, 0);
    set_in(0, 0, 0);

    // Fill the FIFO with 0..15. Watch port A and the almost-full threshold.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, DATA_W'(i), 0);
      #1;
      check("fill_en_a",   en_a,   1);
      check("fill_we_a",   we_a,   4'hF);
      check("fill_addr_a", addr_a, i);
      check("fill_d_a",    d_a,    i);
      tick();
      check("fill_level",  level,  i + 1);
      check("fill_afull",  almost_full, (i + 1) >= 14);
    end
    check("full_flag",  w_full,  1);
    check("full_empty", r_empty, 0);
    set_in(1, 32'hDEAD_BEEF, 0);
    #1;
    check("push_full_en_a", en_a, 0);
    tick();
    check("push_full_level", level, 16);

    // Drain. Each word appears one cycle after its pop.
    for (int i = 0; i < DEPTH; i++) begin
      set_in(0, 0, 1);
      #1;
      check("drain_en_b",   en_b,   1);
      check("drain_addr_b", addr_b, i);
      tick();
      check("drain_valid",  r_valid, 1);
      check("drain_data",   r_data,  i);
      check("drain_level",  level,   15 - i);
      check("drain_afull",  almost_full, (15 - i) >= 14);
    end
    set_in(0, 0, 0);
    check("drain_empty", r_empty, 1);
    tick();
    check("drain_valid_drop", r_valid, 0);
    check("drain_data_hold",  r_data,  32'hF);

    // A pop while empty is ignored.
    set_in(0, 0, 1);
    #1;
    check("pop_empty_en_b", en_b, 0);
    tick();
    check("pop_empty_valid", r_valid, 0);

    // Wrap: the pointers start at 0. Push 10 and pop 10, then push 10 and pop 10.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 10; i++) begin
        set_in(1, 32'h100 * (pass + 1) + i, 0);
        #1;
        check("wrap_addr_a", addr_a, (pass * 10 + i) % DEPTH);
        tick();
      end
      for (int i = 0; i < 10; i++) begin
        set_in(0, 0, 1);
        #1;
        check("wrap_addr_b", addr_b, (pass * 10 + i) % DEPTH);
        tick();
        check("wrap_data", r_data, 32'h100 * (pass + 1) + i);
      end
      set_in(0, 0, 0);
      check("wrap_empty", r_empty, 1);
    end

    // At level 1, a simultaneous push and pop returns the old head.
    set_in(1, 32'hA5A5_A5A5, 0);
    tick();
    set_in(1, 32'h5A5A_5A5A, 1);
    #1;
    check("both_en_a", en_a, 1);
    check("both_en_b", en_b, 1);
    tick();
    check("both_data",  r_data, 32'hA5A5_A5A5);
    check("both_level", level,  1);
    set_in(0, 0, 1);
    tick();
    check("both_next_data", r_data, 32'h5A5A_5A5A);
    check("both_next_level", level, 0);
    set_in(0, 0, 0);

    // With the clock enable low, the controller holds its state and disables both ports.
    set_in(1, 32'h77, 0);
    tick();
    cke = 1'b0;
    set_in(1, 32'h78, 1);
    #1;
    check("cke0_en_a", en_a, 0);
    check("cke0_en_b", en_b, 0);
    tick();
    check("cke0_level", level, 1);
    cke = 1'b1;

    // The synchronous clear wins over a push in the same cycle.
    rst = 1'b1;
    set_in(1, 32'h99, 0);
    #1;
    check("srst_en_a", en_a, 0);
    tick();
    rst = 1'b0;
    set_in(0, 0, 0);
    check("srst_level", level,   0);
    check("srst_empty", r_empty, 1);
    check("srst_data",  r_data,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Backstop against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iob_fifo_sync_dp_ctrl.md
Name: iob_fifo_sync_dp_ctrl

Overview:
Synchronous FIFO controller that drives an external dual-port byte-enable BRAM. It uses port A for pushes and port B for pops, with one-cycle registered read data. It owns the pointers, occupancy level and full/empty flags; the RAM itself is instantiated alongside it by the parent. Typical use is stream buffering between IOb peripherals and a DMA or UART datapath.

Parameters:
- DATA_W, 32: data width in bits; multiple of 8.
- ADDR_W, 4: RAM address width; FIFO depth = 2**ADDR_W.
- ALMOST_FULL_TH, 2**ADDR_W-2: level at or above which almost_full_o asserts.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- cke_i  in  1  clock enable; when 0 all state holds.
- rst_i  in  1  synchronous clear, active-high, qualified by cke_i.
- w_en_i  in  1  push request.
- w_data_i  in  DATA_W  push data.
- w_full_o  out  1  FIFO full.
- almost_full_o  out  1  level >= ALMOST_FULL_TH.
- r_en_i  in  1  pop request.
- r_data_o  out  DATA_W  pop data.
- r_valid_o  out  1  r_data_o holds a popped word.
- r_empty_o  out  1  FIFO empty.
- level_o  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- ext_mem_we_a_o  out  DATA_W/8  port A byte write enables.
- ext_mem_en_a_o  out  1  port A enable.
- ext_mem_addr_a_o  out  ADDR_W  port A address (write pointer).
- ext_mem_d_a_o  out  DATA_W  port A write data.
- ext_mem_en_b_o  out  1  port B enable.
- ext_mem_addr_b_o  out  ADDR_W  port B address (read pointer).
- ext_mem_d_b_i  in  DATA_W  port B read data, valid 1 cycle after en_b.

Behaviour:
- Reset: arst_n_i low clears wptr, rptr, level, r_valid_o and r_data_o to 0. After reset r_empty_o=1, w_full_o=0, almost_full_o=0.
- rst_i=1 with cke_i=1 produces the same clear synchronously. rst_i takes priority over same-cycle push and pop.
- Push accepted = w_en_i & ~w_full_o.
  - Port A driven combinationally: en_a=1, we_a=all ones, addr_a=wptr, d_a=w_data_i.
  - wptr increments on the clock edge.
- Push while full: ignored. No RAM write, no pointer or level change; this holds even if a pop occurs in the same cycle.
- Pop accepted = r_en_i & ~r_empty_o.
  - en_b=1, addr_b=rptr; rptr increments.
  - Next cycle: r_valid_o=1 and r_data_o = ext_mem_d_b_i, registered.
- Pop while empty: ignored, and r_valid_o=0 next cycle.
- r_valid_o is a 1-cycle pulse per accepted pop. r_data_o holds its last value otherwise.
- Level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flags: r_empty_o = (level==0), w_full_o = (level==2**ADDR_W). Both are registered-derived and update the cycle after the edge.
- Pointers are ADDR_W bits and wrap modulo 2**ADDR_W with no special handling.
- Read and write addresses never collide on an active port, because pops are blocked when empty and pushes when full. This makes the BRAM read-first/no-read-on-write choice irrelevant.
- Simultaneous push and pop at level 1: both accepted, and the popped word is the old head, not the new data.
- cke_i=0: no pointer, level or output register updates. Ports en_a and en_b are forced to 0.

Optional Feature:
IOB_FIFO_SYNC_FWFT_EN
- Defined: first-word-fall-through mode.
  - A 1-entry output register is prefetched from the RAM whenever it is empty and RAM data exists.
  - r_valid_o is a level signal meaning the head word is present on r_data_o; r_en_i acknowledges and consumes it.
  - r_empty_o = ~r_valid_o. level_o counts RAM entries plus the output register.
  - The first push into an empty FIFO appears on r_data_o 2 cycles later: RAM write, RAM read, register load.
- Undefined: standard mode exactly as in Behaviour.

Test Plan:
- Reset with arst_n_i=0 mid-stream after 3 pushes -> level_o=0, r_empty_o=1, r_valid_o=0; a following pop gives no en_b.
- ADDR_W=4: push 0x00000000..0x0000000F -> w_full_o=1, level_o=16. A 17th push produces no en_a and level stays 16.
- From full, pop 16 times -> r_data_o sequence 0x0..0xF with r_valid_o one cycle after each r_en_i; r_empty_o=1 at the end.
- Wrap: push 10, pop 10, then push 10 and pop 10 -> data order preserved; addr_a/addr_b wrap from 15 to 0.
- Level 1 holding 0xA5A5A5A5, simultaneous push 0x5A5A5A5A and pop -> r_data_o=0xA5A5A5A5, level_o stays 1, next pop returns 0x5A5A5A5A.
- ALMOST_FULL_TH=14: almost_full_o rises on the cycle after level reaches 14 and falls when level drops to 13. With FWFT_EN, r_data_o=first word 2 cycles after the first push.
